// File: rtl/dsadd_pkg.sv
// Shared defaults and sizing helper for the digit-serial adder/subtractor.
package dsadd_pkg;

  localparam int DEFAULT_DIGIT_W    = 1;
  localparam int DEFAULT_NUM_DIGITS = 8;

  function automatic int cnt_width(input int num_digits);
    return $clog2(num_digits);
  endfunction

endpackage

// File: rtl/dsadd_digit.sv
// Combinational DIGIT_W-wide add/subtract slice; exposes carry-into-MSB only
// when DSADD_OVF_EN is defined.
module dsadd_digit #(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               inv,
  input  logic               cin,
  output logic [DIGIT_W-1:0] sum,
  output logic               cout
`ifdef DSADD_OVF_EN
  ,
  output logic               cmsb
`endif
);

  logic [DIGIT_W-1:0] bx;
  logic [DIGIT_W:0]   full;

  assign bx   = b ^ {DIGIT_W{inv}};
  assign full = {1'b0, a} + {1'b0, bx} + {{DIGIT_W{1'b0}}, cin};
  assign sum  = full[DIGIT_W-1:0];
  assign cout = full[DIGIT_W];

`ifdef DSADD_OVF_EN
  // The MSB sum bit is a^b^carry-in, so the carry into it falls out by XOR.
  assign cmsb = a[DIGIT_W-1] ^ bx[DIGIT_W-1] ^ sum[DIGIT_W-1];
`endif

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial add/subtract, LS digit first, one-cycle latency.
// Define DSADD_OVF_EN to enable the signed-overflow output.
module digit_serial_addsub
  import dsadd_pkg::*;
#(
  parameter int DIGIT_W    = DEFAULT_DIGIT_W,
  parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clean,
  input  logic               in_valid,
  input  logic               sub,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic [DIGIT_W-1:0] s,
  output logic               s_valid,
  output logic               s_last,
  output logic               cout,
  output logic               ovf
);

  localparam int CW = cnt_width(NUM_DIGITS);
  localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

  logic [CW-1:0]      cnt;
  logic               carry;
  logic               op_sub;
  logic               first;
  logic               eff_sub;
  logic               cin;
  logic [DIGIT_W-1:0] sum;
  logic               dcout;

  // The first digit of a word samples sub afresh; later digits reuse op_sub.
  assign first   = (cnt == '0);
  assign eff_sub = first ? sub : op_sub;
  assign cin     = first ? sub : carry;

`ifdef DSADD_OVF_EN
  logic cmsb;
  logic ovf_q;

  dsadd_digit #(.DIGIT_W(DIGIT_W)) u_digit (
    .a    (a),
    .b    (b),
    .inv  (eff_sub),
    .cin  (cin),
    .sum  (sum),
    .cout (dcout),
    .cmsb (cmsb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ovf_q <= 1'b0;
    else if (!clean && in_valid && cnt == LAST)
      ovf_q <= cmsb ^ dcout;
  end

  assign ovf = ovf_q;
`else
  dsadd_digit #(.DIGIT_W(DIGIT_W)) u_digit (
    .a    (a),
    .b    (b),
    .inv  (eff_sub),
    .cin  (cin),
    .sum  (sum),
    .cout (dcout)
  );

  assign ovf = 1'b0;
`endif

  // Carry is dropped on the last digit so back-to-back words never leak.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      carry   <= 1'b0;
      op_sub  <= 1'b0;
      s       <= '0;
      s_valid <= 1'b0;
      s_last  <= 1'b0;
      cout    <= 1'b0;
    end else if (clean) begin
      cnt     <= '0;
      carry   <= 1'b0;
      s_valid <= 1'b0;
      s_last  <= 1'b0;
    end else if (in_valid) begin
      s       <= sum;
      s_valid <= 1'b1;
      op_sub  <= eff_sub;
      if (cnt == LAST) begin
        cnt    <= '0;
        carry  <= 1'b0;
        s_last <= 1'b1;
        cout   <= dcout;
      end else begin
        cnt    <= cnt + CW'(1);
        carry  <= dcout;
        s_last <= 1'b0;
      end
    end else begin
      s_valid <= 1'b0;
      s_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed bench: a bit-serial instance (1x8) and a nibble-serial one (4x2).
module tb_digit_serial_addsub;

`ifdef DSADD_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  logic       clean1, in_valid1, sub1;
  logic [0:0] a1, b1, s1;
  logic       sv1, sl1, co1, ov1;

  logic       clean4, in_valid4, sub4;
  logic [3:0] a4, b4, s4;
  logic       sv4, sl4, co4, ov4;

  int checks = 0;
  int errors = 0;

  logic [7:0] res;
  logic       co, ov;

  always #5 clk = ~clk;

  digit_serial_addsub #(.DIGIT_W(1), .NUM_DIGITS(8)) dut1 (
    .clk(clk), .reset(reset), .clean(clean1), .in_valid(in_valid1), .sub(sub1),
    .a(a1), .b(b1), .s(s1), .s_valid(sv1), .s_last(sl1), .cout(co1), .ovf(ov1)
  );

  digit_serial_addsub #(.DIGIT_W(4), .NUM_DIGITS(2)) dut4 (
    .clk(clk), .reset(reset), .clean(clean4), .in_valid(in_valid4), .sub(sub4),
    .a(a4), .b(b4), .s(s4), .s_valid(sv4), .s_last(sl4), .cout(co4), .ovf(ov4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Sub is inverted after digit 0 to prove it is only sampled at word start.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               input logic op, input int gap,
                               output logic [7:0] r, output logic c,
                               output logic o);
    r = '0;
    c = 1'b0;
    o = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid1 = 1'b1;
      a1 = av[i];
      b1 = bv[i];
      sub1 = (i == 0) ? op : ~op;
      @(posedge clk);
      #1;
      checkOutput("s_valid1", 32'(sv1), 32'd1);
      checkOutput("s_last1", 32'(sl1), 32'(i == 7));
      r[i] = s1[0];
      c = co1;
      o = ov1;
      if (i < 7) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          in_valid1 = 1'b0;
          a1 = ~a1;
          b1 = ~b1;
          @(posedge clk);
          #1;
          checkOutput("gap_valid1", 32'(sv1), 32'd0);
          checkOutput("gap_last1", 32'(sl1), 32'd0);
        end
      end
    end
  endtask

  task automatic applyWord4(input logic [7:0] av, input logic [7:0] bv,
                            input logic op, output logic [7:0] r,
                            output logic c, output logic o);
    r = '0;
    c = 1'b0;
    o = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid4 = 1'b1;
      a4 = av[4*i +: 4];
      b4 = bv[4*i +: 4];
      sub4 = (i == 0) ? op : ~op;
      @(posedge clk);
      #1;
      checkOutput("s_valid4", 32'(sv4), 32'd1);
      checkOutput("s_last4", 32'(sl4), 32'(i == 1));
      r[4*i +: 4] = s4;
      c = co4;
      o = ov4;
    end
  endtask

  initial begin
    reset = 1'b1;
    clean1 = 1'b0; in_valid1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    clean4 = 1'b0; in_valid4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_s", 32'(s1), 32'd0);
    checkOutput("rst_valid", 32'(sv1), 32'd0);
    checkOutput("rst_last", 32'(sl1), 32'd0);
    checkOutput("rst_cout", 32'(co1), 32'd0);
    checkOutput("rst_ovf", 32'(ov1), 32'd0);
    reset = 1'b0;

    // 0x5A + 0x3C = 0x96, signed overflow
    applyStimulus(8'h5A, 8'h3C, 1'b0, 0, res, co, ov);
    checkOutput("add_res", 32'(res), 32'h96);
    checkOutput("add_cout", 32'(co), 32'd0);
    checkOutput("add_ovf", 32'(ov), 32'(OVF_ON));

    // Same word with 3-cycle gaps between digits
    applyStimulus(8'h5A, 8'h3C, 1'b0, 3, res, co, ov);
    checkOutput("gap_res", 32'(res), 32'h96);
    checkOutput("gap_cout", 32'(co), 32'd0);
    checkOutput("gap_ovf", 32'(ov), 32'(OVF_ON));

    // 0x3C - 0x5A = 0xE2 with borrow, no overflow
    applyStimulus(8'h3C, 8'h5A, 1'b1, 0, res, co, ov);
    checkOutput("sub1_res", 32'(res), 32'hE2);
    checkOutput("sub1_cout", 32'(co), 32'd0);
    checkOutput("sub1_ovf", 32'(ov), 32'd0);

    // Hold behaviour while idle
    @(negedge clk);
    in_valid1 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_valid", 32'(sv1), 32'd0);
    checkOutput("idle_last", 32'(sl1), 32'd0);
    checkOutput("idle_hold_s", 32'(s1), 32'd1);

    // Nibble-serial 0x10 - 0x01 = 0x0F, no borrow
    applyWord4(8'h10, 8'h01, 1'b1, res, co, ov);
    checkOutput("sub4_res", 32'(res), 32'h0F);
    checkOutput("sub4_cout", 32'(co), 32'd1);
    checkOutput("sub4_ovf", 32'(ov), 32'd0);

    // Back-to-back words: carry must not leak into the second
    applyWord4(8'hFF, 8'h01, 1'b0, res, co, ov);
    checkOutput("b2b1_res", 32'(res), 32'h00);
    checkOutput("b2b1_cout", 32'(co), 32'd1);
    checkOutput("b2b1_ovf", 32'(ov), 32'd0);
    applyWord4(8'h00, 8'h00, 1'b0, res, co, ov);
    checkOutput("b2b2_res", 32'(res), 32'h00);
    checkOutput("b2b2_cout", 32'(co), 32'd0);
    checkOutput("b2b2_ovf", 32'(ov), 32'd0);
    @(negedge clk);
    in_valid4 = 1'b0;

    // Three digits of 1+1 build a carry, then clean aborts the word
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid1 = 1'b1; sub1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
    end
    @(negedge clk);
    clean1 = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("clean_valid", 32'(sv1), 32'd0);
    checkOutput("clean_last", 32'(sl1), 32'd0);
    @(negedge clk);
    clean1 = 1'b0;
    in_valid1 = 1'b0;
    applyStimulus(8'h01, 8'h01, 1'b0, 0, res, co, ov);
    checkOutput("clean_res", 32'(res), 32'h02);
    checkOutput("clean_cout", 32'(co), 32'd0);
    checkOutput("clean_ovf", 32'(ov), 32'd0);

    // Five digits, asynchronous reset, then 0x80 + 0x80
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid1 = 1'b1; sub1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
    end
    @(negedge clk);
    in_valid1 = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("arst_s", 32'(s1), 32'd0);
    checkOutput("arst_valid", 32'(sv1), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(8'h80, 8'h80, 1'b0, 0, res, co, ov);
    checkOutput("rst_word_res", 32'(res), 32'h00);
    checkOutput("rst_word_cout", 32'(co), 32'd1);
    checkOutput("rst_word_ovf", 32'(ov), 32'(OVF_ON));

    @(negedge clk);
    in_valid1 = 1'b0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
